// File: rtl/axi_line_ctrl_if.sv
// Bundle of request, line-buffer strobe and AXI burst signals for the line controller.
// The master side is the controller itself; the slave side is whatever drives requests
// and models the AXI slave and shift buffer.
interface axi_line_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_rd_req;
  logic                  i_wr_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_fifo_load;
  logic                  o_fifo_shift;
  logic [ADDR_WIDTH-1:0] o_araddr;
  logic [7:0]            o_arlen;
  logic                  o_arvalid;
  logic                  i_arready;
  logic                  i_rvalid;
  logic                  o_rready;
  logic [ADDR_WIDTH-1:0] o_awaddr;
  logic [7:0]            o_awlen;
  logic                  o_awvalid;
  logic                  i_awready;
  logic                  o_wvalid;
  logic                  i_wready;
  logic                  o_wlast;
  logic                  i_bvalid;
  logic                  o_bready;

  modport master (
    input  i_rd_req, i_wr_req, i_addr,
    input  i_arready, i_rvalid, i_awready, i_wready, i_bvalid,
    output o_busy, o_done, o_fifo_load, o_fifo_shift,
    output o_araddr, o_arlen, o_arvalid, o_rready,
    output o_awaddr, o_awlen, o_awvalid, o_wvalid, o_wlast, o_bready
  );

  modport slave (
    output i_rd_req, i_wr_req, i_addr,
    output i_arready, i_rvalid, i_awready, i_wready, i_bvalid,
    input  o_busy, o_done, o_fifo_load, o_fifo_shift,
    input  o_araddr, o_arlen, o_arvalid, o_rready,
    input  o_awaddr, o_awlen, o_awvalid, o_wvalid, o_wlast, o_bready
  );
endinterface

// File: rtl/axi_line_ctrl.sv
// Cache line refill / writeback controller. Issues one fixed-length AXI burst per
// accepted request and steers the external line shift buffer: a parallel load
// before a writeback, one shift per data beat in either direction.
module axi_line_ctrl #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic            i_clk,
  input  logic            i_arst,
  axi_line_ctrl_if.master bus
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((LINE_WIDTH / 8) - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic                  accept;
  logic                  done_set;
  logic                  done_q;

  // Next-state, beat counter and all handshake strobes; the buffer shift is the only
  // output allowed to follow a ready/valid input within the same cycle. Requests are
  // masked while reset is held so the load strobe cannot leak out during reset.
  always_comb begin
    state_next       = state;
    count_next       = count;
    accept           = 1'b0;
    done_set         = 1'b0;
    bus.o_fifo_load  = 1'b0;
    bus.o_fifo_shift = 1'b0;
    bus.o_arvalid    = 1'b0;
    bus.o_rready     = 1'b0;
    bus.o_awvalid    = 1'b0;
    bus.o_wvalid     = 1'b0;
    bus.o_wlast      = 1'b0;
    bus.o_bready     = 1'b0;
    case (state)
      IDLE: begin
        if (!i_arst) begin
          if (bus.i_wr_req) begin
            accept          = 1'b1;
            bus.o_fifo_load = 1'b1;
            count_next      = '0;
            state_next      = WR_ADDR;
          end else if (bus.i_rd_req) begin
            accept     = 1'b1;
            count_next = '0;
            state_next = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        bus.o_arvalid = 1'b1;
        if (bus.i_arready) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        bus.o_rready     = 1'b1;
        bus.o_fifo_shift = bus.i_rvalid;
        if (bus.i_rvalid) begin
          if (count == LAST_BEAT) begin
            count_next = '0;
            done_set   = 1'b1;
            state_next = IDLE;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      WR_ADDR: begin
        bus.o_awvalid = 1'b1;
        if (bus.i_awready) begin
          state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        bus.o_wvalid     = 1'b1;
        bus.o_fifo_shift = bus.i_wready;
        bus.o_wlast      = (count == LAST_BEAT);
        if (bus.i_wready) begin
          if (count == LAST_BEAT) begin
            count_next = '0;
            state_next = WR_RESP;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      WR_RESP: begin
        bus.o_bready = 1'b1;
        if (bus.i_bvalid) begin
          done_set   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, beat counter and the registered completion pulse; reset aborts silently.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      done_q <= done_set;
    end
  end

  // Line-aligned address captured on acceptance and held for the whole transaction.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      line_addr <= '0;
    end else if (accept) begin
      line_addr <= bus.i_addr & ~LINE_MASK;
    end
  end

  assign bus.o_busy   = (state != IDLE);
  assign bus.o_done   = done_q;
  assign bus.o_araddr = line_addr;
  assign bus.o_awaddr = line_addr;
  assign bus.o_arlen  = 8'(BEATS - 1);
  assign bus.o_awlen  = 8'(BEATS - 1);

endmodule

// File: tb/tb_axi_line_ctrl.sv
// Scoreboard bench for the line controller: stimulus pushes the expected event
// sequence (load, AR, AW, shifts with wlast flag, done); a negedge monitor pops and
// compares each event the controller actually produces.
module tb_axi_line_ctrl;

  typedef enum int {EV_LOAD, EV_AR, EV_AW, EV_SHIFT, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] data;
  } ev_t;

  logic clk;
  logic arst;
  int   num_checks;
  int   num_fails;
  ev_t  exp_q[$];

  axi_line_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  axi_line_ctrl #(
    .AXI_DATA_WIDTH(32),
    .LINE_WIDTH(512),
    .ADDR_WIDTH(32)
  ) dut (
    .i_clk (clk),
    .i_arst(arst),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_t kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input ev_kind_t kind, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      num_checks++;
      num_fails++;
      $display("[TB] FAIL unexpected_event: got kind %0d data 0x%08h, expected nothing at %0t",
               kind, data, $time);
    end else begin
      e = exp_q.pop_front();
      check_output("event_kind", 32'(kind), 32'(e.kind));
      check_output("event_data", data, e.data);
    end
  endtask

  // Monitor: every observable event is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!arst) begin
      if (bus.o_fifo_load) check_event(EV_LOAD, 32'h0);
      if (bus.o_arvalid && bus.i_arready) check_event(EV_AR, bus.o_araddr);
      if (bus.o_awvalid && bus.i_awready) check_event(EV_AW, bus.o_awaddr);
      if (bus.o_fifo_shift) check_event(EV_SHIFT, {31'b0, bus.o_wlast});
      if (bus.o_done) check_event(EV_DONE, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the done pulse with a cycle budget; returns ticks spent.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!bus.o_done && n < budget) begin
      tick();
      n++;
    end
    check_output("done_seen", 32'(bus.o_done), 32'h1);
    tick();
  endtask

  task automatic push_read(input logic [31:0] aligned);
    push_ev(EV_AR, aligned);
    for (int i = 0; i < 16; i++) push_ev(EV_SHIFT, 32'h0);
    push_ev(EV_DONE, 32'h0);
  endtask

  // Full writeback with optional wready toggling, B delay, colliding read and
  // a read pulse injected while the data phase is running.
  task automatic run_write(input logic [31:0] addr, input logic [31:0] aligned,
                           input bit toggle, input int resp_delay,
                           input bit also_rd, input bit inject_rd);
    int n;
    int resp;
    bit injected;
    push_ev(EV_LOAD, 32'h0);
    push_ev(EV_AW, aligned);
    for (int i = 0; i < 16; i++) push_ev(EV_SHIFT, (i == 15) ? 32'h1 : 32'h0);
    push_ev(EV_DONE, 32'h0);
    bus.i_addr    = addr;
    bus.i_wr_req  = 1'b1;
    bus.i_rd_req  = also_rd;
    bus.i_awready = 1'b1;
    bus.i_wready  = 1'b1;
    bus.i_bvalid  = 1'b0;
    #1;
    check_output("fifo_load_same_cycle", 32'(bus.o_fifo_load), 32'h1);
    tick();
    bus.i_wr_req = 1'b0;
    bus.i_rd_req = 1'b0;
    check_output("awvalid_after_accept", 32'(bus.o_awvalid), 32'h1);
    check_output("awaddr_aligned", bus.o_awaddr, aligned);
    n = 0;
    resp = 0;
    injected = 1'b0;
    while (!bus.o_done && n < 200) begin
      if (toggle) bus.i_wready = ~bus.i_wready;
      if (bus.o_bready) resp++;
      bus.i_bvalid = bus.o_bready && (resp >= resp_delay);
      if (inject_rd && bus.o_wvalid && !injected) begin
        bus.i_rd_req = 1'b1;
        injected = 1'b1;
      end else begin
        bus.i_rd_req = 1'b0;
      end
      tick();
      n++;
    end
    check_output("write_done_seen", 32'(bus.o_done), 32'h1);
    bus.i_bvalid = 1'b0;
    bus.i_wready = 1'b0;
    bus.i_rd_req = 1'b0;
    tick();
  endtask

  task automatic apply_stimulus();
    int n;
    // Reset state, with requests and readies asserted to prove they are ignored.
    arst = 1'b1;
    bus.i_rd_req  = 1'b1;
    bus.i_wr_req  = 1'b1;
    bus.i_addr    = 32'hFFFF_FFFF;
    bus.i_arready = 1'b1;
    bus.i_rvalid  = 1'b1;
    bus.i_awready = 1'b1;
    bus.i_wready  = 1'b1;
    bus.i_bvalid  = 1'b1;
    repeat (3) tick();
    check_output("rst_busy", 32'(bus.o_busy), 32'h0);
    check_output("rst_fifo_load", 32'(bus.o_fifo_load), 32'h0);
    check_output("rst_arvalid", 32'(bus.o_arvalid), 32'h0);
    check_output("rst_araddr", bus.o_araddr, 32'h0);
    check_output("rst_done", 32'(bus.o_done), 32'h0);
    check_output("rst_arlen", 32'(bus.o_arlen), 32'd15);
    check_output("rst_awlen", 32'(bus.o_awlen), 32'd15);
    bus.i_rd_req = 1'b0;
    bus.i_wr_req = 1'b0;
    bus.i_bvalid = 1'b0;
    bus.i_wready = 1'b0;
    tick();
    arst = 1'b0;
    tick();

    // Refill at 0x1234 with AR and R always ready: done 17 cycles after AR.
    $display("[TB] read 0x1234");
    push_read(32'h0000_1200);
    bus.i_addr   = 32'h0000_1234;
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    check_output("read_arvalid_cycle1", 32'(bus.o_arvalid), 32'h1);
    check_output("read_busy", 32'(bus.o_busy), 32'h1);
    wait_done(100, n);
    check_output("read_latency", 32'(n), 32'd17);

    // Writeback at 0x80, wready toggling, B three cycles into the response phase.
    $display("[TB] write 0x80");
    run_write(32'h0000_0080, 32'h0000_0080, 1'b1, 3, 1'b0, 1'b0);

    // Colliding read and write pulses: only the write may run.
    $display("[TB] simultaneous rd+wr");
    run_write(32'hABCD_EF7F, 32'hABCD_EF40, 1'b0, 1, 1'b1, 1'b0);

    // Read pulse while the write data phase is running must be dropped.
    $display("[TB] read pulse while busy");
    run_write(32'h0000_0100, 32'h0000_0100, 1'b0, 2, 1'b0, 1'b1);
    repeat (5) tick();

    // AR stalled five cycles: address stable, no shifting before the handshake.
    $display("[TB] arready withheld");
    bus.i_arready = 1'b0;
    push_read(32'h0000_2440);
    bus.i_addr   = 32'h0000_2468;
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    bus.i_addr   = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      check_output("stall_arvalid", 32'(bus.o_arvalid), 32'h1);
      check_output("stall_araddr", bus.o_araddr, 32'h0000_2440);
      check_output("stall_no_shift", 32'(bus.o_fifo_shift), 32'h0);
      tick();
    end
    bus.i_arready = 1'b1;
    wait_done(100, n);

    // Reset in the middle of a refill: seven beats shifted, then silent abort.
    $display("[TB] reset mid-burst");
    push_ev(EV_AR, 32'h0000_4000);
    for (int i = 0; i < 7; i++) push_ev(EV_SHIFT, 32'h0);
    bus.i_addr   = 32'h0000_4000;
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    repeat (8) tick();
    arst = 1'b1;
    #1;
    check_output("abort_busy", 32'(bus.o_busy), 32'h0);
    check_output("abort_rready", 32'(bus.o_rready), 32'h0);
    check_output("abort_shift", 32'(bus.o_fifo_shift), 32'h0);
    check_output("abort_araddr", bus.o_araddr, 32'h0);
    repeat (2) tick();
    check_output("abort_no_done", 32'(bus.o_done), 32'h0);
    arst = 1'b0;
    tick();
    check_output("abort_no_done_after", 32'(bus.o_done), 32'h0);

    // Next refill after reset proceeds normally.
    $display("[TB] read after reset");
    push_read(32'hFFFF_FFC0);
    bus.i_addr   = 32'hFFFF_FFC5;
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    wait_done(100, n);
    check_output("read2_latency", 32'(n), 32'd17);
    repeat (4) tick();
  endtask

  initial begin
    num_checks = 0;
    num_fails  = 0;
    arst = 1'b1;
    bus.i_rd_req  = 1'b0;
    bus.i_wr_req  = 1'b0;
    bus.i_addr    = 32'h0;
    bus.i_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_awready = 1'b0;
    bus.i_wready  = 1'b0;
    bus.i_bvalid  = 1'b0;
    apply_stimulus();
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/axi_line_ctrl.md
AXI_LINE_CTRL -- requirements
Module: axi_line_ctrl

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 32, AXI data beat width in bits.
REQ-002 Parameter LINE_WIDTH, default 512, cache line width in bits; BEATS = LINE_WIDTH/AXI_DATA_WIDTH (16 by default).
REQ-003 Parameter ADDR_WIDTH, default 32, AXI address width in bits.
REQ-004 i_clk  in  1  clock; all state changes on the rising edge.
REQ-005 i_arst  in  1  reset, asynchronous, active-high.
REQ-006 i_rd_req  in  1  single-cycle pulse requesting a line refill.
REQ-007 i_wr_req  in  1  single-cycle pulse requesting a line writeback.
REQ-008 i_addr  in  ADDR_WIDTH  line address, sampled with the accepted request.
REQ-009 o_busy  out  1  high whenever the FSM is not in IDLE.
REQ-010 o_done  out  1  one-cycle pulse when a transaction completes.
REQ-011 o_fifo_load  out  1  parallel-load strobe to the line shift buffer.
REQ-012 o_fifo_shift  out  1  shift strobe to the line shift buffer.
REQ-013 o_araddr  out  ADDR_WIDTH  read burst address.
REQ-014 o_arlen  out  8  read burst length, constant BEATS-1.
REQ-015 o_arvalid / i_arready  out/in  1  AR handshake.
REQ-016 i_rvalid / o_rready  in/out  1  R handshake; R data goes directly to the buffer, not through this block.
REQ-017 o_awaddr  out  ADDR_WIDTH  write burst address.
REQ-018 o_awlen  out  8  write burst length, constant BEATS-1.
REQ-019 o_awvalid / i_awready  out/in  1  AW handshake.
REQ-020 o_wvalid / i_wready / o_wlast  out/in/out  1  W handshake and last-beat flag.
REQ-021 i_bvalid / o_bready  in/out  1  B handshake; response code is not inspected.

Function
REQ-022 The FSM SHALL have states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
REQ-023 Requests SHALL be accepted only in IDLE; pulses arriving in any other state SHALL be dropped.
REQ-024 If i_wr_req and i_rd_req are high in the same IDLE cycle, the write SHALL win and the read SHALL be dropped.
REQ-025 On acceptance, the address SHALL be latched line-aligned: i_addr with its low log2(LINE_WIDTH/8) bits forced to 0. It drives o_araddr/o_awaddr until the next acceptance.
REQ-026 Accepting a write SHALL assert o_fifo_load combinationally in that same IDLE cycle, then move to WR_ADDR.
REQ-027 Accepting a read SHALL move to RD_ADDR; o_fifo_load SHALL NOT assert.
REQ-028 o_arvalid SHALL be high throughout RD_ADDR and held until i_arready; the handshake cycle moves to RD_DATA.
REQ-029 o_awvalid SHALL be high throughout WR_ADDR and held until i_awready; the handshake cycle moves to WR_DATA.
REQ-030 RD_DATA: o_rready=1; o_fifo_shift = i_rvalid & o_rready; the beat counter increments per handshake; the handshake at count BEATS-1 moves to IDLE. i_rlast is not used.
REQ-031 WR_DATA: o_wvalid=1; o_fifo_shift = i_wready; o_wlast=1 when count==BEATS-1; the handshake at that count moves to WR_RESP.
REQ-032 WR_RESP: o_bready=1; i_bvalid moves to IDLE.
REQ-033 The beat counter SHALL be log2(BEATS) bits wide, cleared on every acceptance, and never wrap mid-burst.
REQ-034 o_done SHALL be a registered pulse, high for exactly the one cycle after the final R handshake or the B handshake.
REQ-035 Handshake outputs SHALL not depend combinationally on the corresponding ready/valid input except o_fifo_shift.

Reset
REQ-036 While i_arst is high, the FSM SHALL be IDLE, the counter 0, the latched address 0, and every output 0 except o_arlen/o_awlen, immediately and regardless of clock.
REQ-037 Reset mid-burst SHALL abort without o_done; the first request after release SHALL proceed normally.

Verification
REQ-038 Read, addr 0x1234, arready and rvalid always high: arvalid in cycle 1 with araddr 0x1200, 16 shifts in cycles 2-17, o_done in cycle 18.
REQ-039 Write, addr 0x80: o_fifo_load in cycle 0, awaddr 0x80; wready toggling 1/0 -> 16 shifts, wlast only on the 16th beat; bvalid after 3 cycles -> o_done the next cycle.
REQ-040 Simultaneous rd+wr pulses in IDLE: write executes; the read is dropped; no AR is issued.
REQ-041 rd_req pulse while busy in WR_DATA: ignored; no AR issued after o_done.
REQ-042 arready withheld 5 cycles: arvalid and araddr stay stable all 5 cycles; no shift occurs before the handshake.
REQ-043 i_arst asserted at beat 7 of a read: all valids drop the same cycle, no o_done; a new read then completes with 16 shifts.
